// File: rtl/logic_reduce_tree_pipe.sv
// Pipelined OR/AND/XOR reduction tree with per-lane valid masking, a per-batch op tag and a global stall.
// Each tree level is one register stage. Latency is max(1, $clog2(NUM_INPUT_DATA)) enabled cycles.
module logic_reduce_tree_pipe #(
    parameter int NUM_INPUT_DATA = 16,
    parameter int DATA_WIDTH     = 8,
    localparam int NUM_LEVEL     = $clog2(NUM_INPUT_DATA),
    localparam int CNT_WIDTH     = $clog2(NUM_INPUT_DATA + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_en,
    input  logic [1:0]                           i_op,
    input  logic [NUM_INPUT_DATA-1:0]            i_valid,
    input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_data_bus,
    output logic                                 o_valid,
    output logic [DATA_WIDTH-1:0]                o_data_bus,
    output logic [CNT_WIDTH-1:0]                 o_count,
    output logic [1:0]                           o_op
);

    localparam int NUM_STAGE = (NUM_LEVEL < 1) ? 1 : NUM_LEVEL;

    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;

    function automatic int nodes_at(input int level);
        int n;
        n = NUM_INPUT_DATA;
        for (int i = 0; i < level; i++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] identity(input logic [1:0] op);
        return (op == OP_AND) ? '1 : '0;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] combine(input logic [1:0]            op,
                                                      input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            default: return a | b;
        endcase
    endfunction

    // Invalid lanes become the identity of the op so they cannot disturb the result.
    logic [DATA_WIDTH-1:0] masked_data  [NUM_INPUT_DATA];
    logic                  masked_valid [NUM_INPUT_DATA];
    logic [CNT_WIDTH-1:0]  masked_count [NUM_INPUT_DATA];

    always_comb begin
        for (int k = 0; k < NUM_INPUT_DATA; k++) begin
            masked_valid[k] = i_valid[k];
            masked_count[k] = CNT_WIDTH'(i_valid[k]);
            masked_data[k]  = i_valid[k] ? i_data_bus[k*DATA_WIDTH +: DATA_WIDTH] : identity(i_op);
        end
    end

    for (genvar s = 0; s < NUM_STAGE; s++) begin : g_stage
        logic [1:0] op_src;
        logic [1:0] op_q;

        if (s == 0) begin : g_op_src
            assign op_src = i_op;
        end else begin : g_op_src
            assign op_src = g_stage[s-1].op_q;
        end

        // NOTE: synchronous reset wins over the enable, so a reset also flushes a stalled pipe.
        always_ff @(posedge clk) begin
            if (rst)       op_q <= 2'd0;
            else if (i_en) op_q <= op_src;
        end

        for (genvar j = 0; j < nodes_at(s + 1); j++) begin : g_node
            localparam bit PAIR = (2 * j + 1 < nodes_at(s));

            logic [DATA_WIDTH-1:0] a_data, b_data, data_q;
            logic                  a_valid, b_valid, valid_q;
            logic [CNT_WIDTH-1:0]  a_count, b_count, count_q;

            if (s == 0) begin : g_a
                assign a_data  = masked_data[2*j];
                assign a_valid = masked_valid[2*j];
                assign a_count = masked_count[2*j];
            end else begin : g_a
                assign a_data  = g_stage[s-1].g_node[2*j].data_q;
                assign a_valid = g_stage[s-1].g_node[2*j].valid_q;
                assign a_count = g_stage[s-1].g_node[2*j].count_q;
            end

            // An odd last node is paired with the identity, which makes it a plain pass-through.
            if (!PAIR) begin : g_b
                assign b_data  = identity(op_src);
                assign b_valid = 1'b0;
                assign b_count = '0;
            end else if (s == 0) begin : g_b
                assign b_data  = masked_data[2*j+1];
                assign b_valid = masked_valid[2*j+1];
                assign b_count = masked_count[2*j+1];
            end else begin : g_b
                assign b_data  = g_stage[s-1].g_node[2*j+1].data_q;
                assign b_valid = g_stage[s-1].g_node[2*j+1].valid_q;
                assign b_count = g_stage[s-1].g_node[2*j+1].count_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                    count_q <= '0;
                end else if (i_en) begin
                    data_q  <= combine(op_src, a_data, b_data);
                    valid_q <= a_valid | b_valid;
                    count_q <= a_count + b_count;
                end
            end
        end
    end

    assign o_valid    = g_stage[NUM_STAGE-1].g_node[0].valid_q;
    assign o_data_bus = g_stage[NUM_STAGE-1].g_node[0].data_q;
    assign o_count    = g_stage[NUM_STAGE-1].g_node[0].count_q;
    assign o_op       = g_stage[NUM_STAGE-1].op_q;

endmodule
